// File: rtl/sha_pad_pkg.sv
// Shared constants, FSM state encoding and port records for the SHA-256 padding stage.
package sha_pad_pkg;

  localparam int BLOCK_BITS = 512;
  localparam int LEN_BITS   = 64;
  localparam int NB         = BLOCK_BITS / 8;       // bytes per block
  localparam int LEN_POS    = NB - LEN_BITS / 8;    // first byte of the length field (56)
  localparam int CNT_BITS   = LEN_BITS - 3;         // byte counter; bit length = count * 8

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_SEND = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       empty;
    logic       blk_ready;
  } sha_pad_in_type;

  typedef struct packed {
    logic                  in_ready;
    logic                  blk_valid;
    logic [BLOCK_BITS-1:0] blk_data;
    logic                  blk_first;
    logic                  blk_last;
  } sha_pad_out_type;

endpackage

// File: rtl/sha_pad.sv
// Byte-stream to 512-bit block packer with SHA-256 message padding (0x80, zero fill, 64-bit length).
module sha_pad
  import sha_pad_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  input  logic                  in_empty,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [BLOCK_BITS-1:0] blk_data,
  output logic                  blk_first,
  output logic                  blk_last
);

  state_t                state, state_next;
  logic [BLOCK_BITS-1:0] blk_buf, fill_buf, tail_buf;
  logic [5:0]            idx;
  logic [CNT_BITS-1:0]   byte_cnt, cnt_next;
  logic                  tail_pend, tail_mark, first, last_blk;
  logic                  accept, take_byte, fin, blk_full;
  logic [6:0]            n;
  sha_pad_in_type        in_rec;
  sha_pad_out_type       out_rec;

  // Byte 0 sits in the top byte lane of the block (big-endian packing).
  function automatic logic [BLOCK_BITS-1:0] put_byte(input logic [BLOCK_BITS-1:0] b,
                                                     input logic [5:0]            pos,
                                                     input logic [7:0]            v);
    logic [BLOCK_BITS-1:0] r;
    r = b;
    r[(NB - 1 - int'(pos)) * 8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [LEN_BITS-1:0] len_field(input logic [CNT_BITS-1:0] c);
    return {c, 3'b000};
  endfunction

  assign in_rec.valid     = in_valid;
  assign in_rec.data      = in_data;
  assign in_rec.last      = in_last;
  assign in_rec.empty     = in_empty;
  assign in_rec.blk_ready = blk_ready;

  // Beat decode: an empty beat is only meaningful when it also ends the message.
  always_comb begin
    accept    = in_rec.valid && (state == S_FILL) && (!in_rec.empty || in_rec.last);
    take_byte = accept && !in_rec.empty;
    fin       = accept && in_rec.last;
    n         = {1'b0, idx} + {6'b0, take_byte};
    blk_full  = take_byte && (n == 7'(NB));
    cnt_next  = byte_cnt + CNT_BITS'(take_byte);
  end

  // Next buffer contents for a fill-state beat and for the extra tail block.
  always_comb begin
    fill_buf = blk_buf;
    if (take_byte)
      fill_buf = put_byte(fill_buf, idx, in_rec.data);
    if (fin && (n < 7'(NB)))
      fill_buf = put_byte(fill_buf, n[5:0], 8'h80);
    if (fin && (n < 7'(LEN_POS)))
      fill_buf[LEN_BITS-1:0] = len_field(cnt_next);

    tail_buf = '0;
    tail_buf[BLOCK_BITS-1 -: 8] = tail_mark ? 8'h80 : 8'h00;
    tail_buf[LEN_BITS-1:0]      = len_field(byte_cnt);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL: if (fin || blk_full) state_next = S_SEND;
      S_SEND: if (in_rec.blk_ready) state_next = tail_pend ? S_TAIL : S_FILL;
      S_TAIL: state_next = S_SEND;
      default: state_next = S_FILL;
    endcase
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    out_rec.in_ready  = !rst && (state == S_FILL);
    out_rec.blk_valid = !rst && (state == S_SEND);
    out_rec.blk_data  = rst ? '0 : blk_buf;
    out_rec.blk_first = out_rec.blk_valid && first;
    out_rec.blk_last  = out_rec.blk_valid && last_blk;
  end

  assign in_ready  = out_rec.in_ready;
  assign blk_valid = out_rec.blk_valid;
  assign blk_data  = out_rec.blk_data;
  assign blk_first = out_rec.blk_first;
  assign blk_last  = out_rec.blk_last;

  // Buffer, byte index, message counter and block flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_buf   <= '0;
      idx       <= '0;
      byte_cnt  <= '0;
      first     <= 1'b1;
      last_blk  <= 1'b0;
      tail_pend <= 1'b0;
      tail_mark <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            blk_buf  <= fill_buf;
            byte_cnt <= cnt_next;
            idx      <= n[5:0];
            if (fin) begin
              // Length fits only if the 0x80 marker lands before the length field.
              last_blk  <= (n < 7'(LEN_POS));
              tail_pend <= (n >= 7'(LEN_POS));
              tail_mark <= (n == 7'(NB));
            end else if (blk_full) begin
              last_blk  <= 1'b0;
              tail_pend <= 1'b0;
            end
          end
        end
        S_SEND: begin
          if (in_rec.blk_ready) begin
            blk_buf <= '0;
            idx     <= '0;
            if (!tail_pend && last_blk) begin
              byte_cnt <= '0;
              first    <= 1'b1;
            end else begin
              first <= 1'b0;
            end
          end
        end
        S_TAIL: begin
          blk_buf   <= tail_buf;
          last_blk  <= 1'b1;
          tail_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_pad.sv
// Directed bench for sha_pad: reference padding model feeds a block scoreboard.
module tb_sha_pad;
  import sha_pad_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [7:0]            in_data = 8'h00;
  logic                  in_last = 1'b0;
  logic                  in_empty = 1'b0;
  logic                  blk_valid;
  logic                  blk_ready = 1'b1;
  logic [BLOCK_BITS-1:0] blk_data;
  logic                  blk_first;
  logic                  blk_last;

  typedef struct packed {
    logic [BLOCK_BITS-1:0] data;
    logic                  first;
    logic                  last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  sha_pad dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BLOCK_BITS-1:0] obs,
                       input logic [BLOCK_BITS-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference padding: msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_expected();
    logic [7:0]    pad[$];
    logic [63:0]   bit_len;
    int            nblk;
    exp_t          e;
    pad = msg_q;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    bit_len = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(bit_len[8*i +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[(63 - j) * 8 +: 8] = pad[b * 64 + j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // Drive one beat from a negedge; returns on the negedge after it was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("in_ready_timeout", BLOCK_BITS'(in_ready), BLOCK_BITS'(1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic send_msg(input bit expect_out);
    if (expect_out) build_expected();
    if (msg_q.size() == 0) send_beat(8'h00, 1'b1, 1'b1);
    else
      for (int i = 0; i < msg_q.size(); i++)
        send_beat(msg_q[i], (i == msg_q.size() - 1), 1'b0);
  endtask

  task automatic fill_msg(input int len, input logic [7:0] v);
    msg_q.delete();
    repeat (len) msg_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check(tag, BLOCK_BITS'(exp_q.size()), BLOCK_BITS'(0));
    @(negedge clk);
  endtask

  // Scoreboard: every block handshake pops and compares one expected block.
  always @(negedge clk) begin
    #1;
    if (blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", BLOCK_BITS'(blk_valid), BLOCK_BITS'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("blk_data", blk_data, e.data);
        check("blk_first", BLOCK_BITS'(blk_first), BLOCK_BITS'(e.first));
        check("blk_last", BLOCK_BITS'(blk_last), BLOCK_BITS'(e.last));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_blk_valid", BLOCK_BITS'(blk_valid), BLOCK_BITS'(0));
    check("rst_in_ready", BLOCK_BITS'(in_ready), BLOCK_BITS'(0));
    check("rst_blk_data", blk_data, '0);
    check("rst_blk_first", BLOCK_BITS'(blk_first), BLOCK_BITS'(0));
    check("rst_blk_last", BLOCK_BITS'(blk_last), BLOCK_BITS'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", BLOCK_BITS'(in_ready), BLOCK_BITS'(1));

    // "abc": single block, valid the cycle after the final beat
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b1);
    check("abc_latency", BLOCK_BITS'(blk_valid), BLOCK_BITS'(1));
    drain("abc_drain");

    // Empty message
    msg_q.delete();
    send_msg(1'b1);
    drain("empty_drain");

    // 56 bytes: marker fills block 1, length goes in a tail block
    fill_msg(56, 8'h61);
    send_msg(1'b1);
    drain("len56_drain");

    // 64 bytes: full block, then tail with marker at byte 0
    fill_msg(64, 8'h61);
    send_msg(1'b1);
    drain("len64_drain");

    // 55 bytes: largest message that still fits in one block
    fill_msg(55, 8'h3c);
    send_msg(1'b1);
    drain("len55_drain");

    // 120 bytes: two-block message whose second block needs a tail
    fill_msg(120, 8'ha5);
    send_msg(1'b1);
    drain("len120_drain");

    // Empty beat without last is ignored mid-message
    msg_q = '{8'h61, 8'h62, 8'h63};
    build_expected();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h00, 1'b0, 1'b1);
    send_beat(8'h63, 1'b1, 1'b0);
    drain("empty_nolast_drain");

    // Backpressure: block held 5 cycles, stray beats ignored
    blk_ready = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b1);
    in_valid = 1'b1;
    in_data  = 8'hff;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", BLOCK_BITS'(blk_valid), BLOCK_BITS'(1));
      check("bp_data", blk_data, exp_q[0].data);
      check("bp_in_ready", BLOCK_BITS'(in_ready), BLOCK_BITS'(0));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after", BLOCK_BITS'(in_ready), BLOCK_BITS'(1));
    check("bp_valid_after", BLOCK_BITS'(blk_valid), BLOCK_BITS'(0));
    drain("bp_drain");

    // Reset mid-message, then "abc" must match a fresh message
    fill_msg(30, 8'h5a);
    send_msg(1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmsg_valid", BLOCK_BITS'(blk_valid), BLOCK_BITS'(0));
    check("rstmsg_in_ready", BLOCK_BITS'(in_ready), BLOCK_BITS'(0));
    rst = 1'b0;
    @(negedge clk);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b1);
    drain("rstmsg_drain");

    // Reset while a block is pending
    blk_ready = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    check("rstsend_valid_before", BLOCK_BITS'(blk_valid), BLOCK_BITS'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstsend_valid_after", BLOCK_BITS'(blk_valid), BLOCK_BITS'(0));
    check("rstsend_in_ready", BLOCK_BITS'(in_ready), BLOCK_BITS'(1));
    blk_ready = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b1);
    drain("rstsend_drain");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
